sdram_responder: RTL and testbench

- Cycle-accurate, synthesizable single-chip SDRAM device model that sits on the far side of the SDRAM controller's command/address/data pins.
- Decodes RAS/CAS/WE commands, tracks per-bank open rows and the mode register, stores data in a small internal array, and returns read data after the programmed CAS latency.
- Checks protocol timing and reports violations, so controller benches and on-FPGA loopback tests have a live, checking target.

---
 rtl/sdram_responder.sv | 250 +++++++++++++++++++++++++
 tb/tb_sdram_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// Single-chip SDRAM device model: decodes controller commands, tracks banks and mode,
// stores data in a small array, returns reads after CAS latency and flags protocol violations.
module sdram_responder #(
    parameter int ROW_BITS    = 3,
    parameter int COL_BITS    = 8,
    parameter int T_RCD       = 1,
    parameter int T_RFC       = 2,
    parameter int REFRESH_MAX = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ras_n,
    input  logic        cas_n,
    input  logic        we_n,
    input  logic [1:0]  ba,
    input  logic [10:0] addr,
    input  logic [31:0] dq_in,
    output logic [31:0] dq_out,
    output logic        dq_oe,
    output logic        err_valid,
    output logic [2:0]  err_code,
    output logic [7:0]  err_flags,
    output logic        mode_set,
    output logic [1:0]  cas_latency,
    output logic [15:0] refresh_count
);

    localparam int MEM_AW = 2 + ROW_BITS + COL_BITS;
    localparam int RCD_W  = (T_RCD > 0) ? $clog2(T_RCD + 1) : 1;
    localparam int RFC_W  = (T_RFC > 0) ? $clog2(T_RFC + 1) : 1;
    localparam int REF_W  = $clog2(REFRESH_MAX + 1);

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_RSV = 3'b110,
        CMD_NOP = 3'b111
    } cmd_e;

    // Bank, mode and timer state
    logic [3:0]        r_open;
    logic [10:0]       r_row [4];
    logic [RCD_W-1:0]  r_rcd [4];
    logic [RFC_W-1:0]  r_rfc;
    logic [REF_W-1:0]  r_ref_timer;
    logic              r_mode_set;
    logic [1:0]        r_cl;
    logic [15:0]       r_ref_cnt;

    // Read pipeline: slot 0 feeds the output register, slot 1 adds one cycle for CL=3
    logic [1:0]        r_p_vld;
    logic [31:0]       r_p_dat [2];
    logic [31:0]       r_dq_out;
    logic              r_dq_oe;
    logic              r_err_valid;
    logic [2:0]        r_err_code;
    logic [7:0]        r_err_flags;

    logic [31:0]       r_mem [2**MEM_AW];

    cmd_e              w_cmd;
    logic              w_bank_open;
    logic              w_row_hit;
    logic              w_rcd_done;
    logic              w_any_open;
    logic              w_is_rw;
    logic              w_rw_ok;
    logic              w_wr_ok;
    logic              w_rd_push;
    logic              w_mrs_bad;
    logic              w_mrs_ok;
    logic              w_ref_late;
    logic              w_cmd_active;
    logic [7:0]        w_err;
    logic [2:0]        w_err_code;
    logic [MEM_AW-1:0] w_mem_idx;
    logic [31:0]       w_rd_word;

    // Command decode and legality of the command presented this cycle
    always_comb begin
        w_cmd        = cmd_e'({ras_n, cas_n, we_n});
        w_bank_open  = r_open[ba];
        w_row_hit    = (r_row[ba] == addr);
        w_rcd_done   = (r_rcd[ba] == RCD_W'(0));
        w_any_open   = |r_open;
        w_is_rw      = (w_cmd == CMD_RD) || (w_cmd == CMD_WR);
        w_cmd_active = (w_cmd != CMD_NOP) && (w_cmd != CMD_RSV);
        w_rw_ok      = r_mode_set && w_is_rw && w_bank_open && w_rcd_done;
        w_wr_ok      = w_rw_ok && (w_cmd == CMD_WR);
        w_rd_push    = w_rw_ok && (w_cmd == CMD_RD);
        w_mrs_bad    = ((addr[6:4] != 3'd2) && (addr[6:4] != 3'd3)) ||
                       (addr[2:0] != 3'd0) || w_any_open;
        w_mrs_ok     = (w_cmd == CMD_MRS) && !w_mrs_bad;
        w_ref_late   = r_mode_set && (r_ref_timer == REF_W'(REFRESH_MAX - 1)) &&
                       (w_cmd != CMD_REF) && !w_mrs_ok;
        w_mem_idx    = {ba, r_row[ba][ROW_BITS-1:0], addr[COL_BITS-1:0]};
    end

    assign w_rd_word = r_mem[w_mem_idx];

    // Violation vector for this cycle and lowest-code priority pick
    always_comb begin
        w_err    = 8'd0;
        w_err[0] = !r_mode_set && ((w_cmd == CMD_ACT) || w_is_rw);
        w_err[1] = (w_cmd == CMD_MRS) && w_mrs_bad;
        w_err[2] = r_mode_set && (w_cmd == CMD_ACT) && w_bank_open && !w_row_hit;
        w_err[3] = r_mode_set && w_is_rw && !w_bank_open;
        w_err[4] = r_mode_set && w_is_rw && w_bank_open && !w_rcd_done;
        w_err[5] = (w_cmd == CMD_REF) && w_any_open;
        w_err[6] = (r_rfc != RFC_W'(0)) && w_cmd_active;
        w_err[7] = w_ref_late;
        casez (w_err)
            8'b???????1: w_err_code = 3'd0;
            8'b??????10: w_err_code = 3'd1;
            8'b?????100: w_err_code = 3'd2;
            8'b????1000: w_err_code = 3'd3;
            8'b???10000: w_err_code = 3'd4;
            8'b??100000: w_err_code = 3'd5;
            8'b?1000000: w_err_code = 3'd6;
            8'b10000000: w_err_code = 3'd7;
            default:     w_err_code = 3'd0;
        endcase
    end

    // Per-bank open/row tracking and tRCD countdown
    always_ff @(posedge clk) begin
        if (rst) begin
            r_open <= 4'b0000;
            for (int b = 0; b < 4; b++) begin
                r_row[b] <= 11'd0;
                r_rcd[b] <= RCD_W'(0);
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (r_rcd[b] != RCD_W'(0)) begin
                    r_rcd[b] <= r_rcd[b] - RCD_W'(1);
                end
            end
            case (w_cmd)
                CMD_ACT: begin
                    if (r_mode_set && !w_bank_open) begin
                        r_open[ba] <= 1'b1;
                        r_row[ba]  <= addr;
                        r_rcd[ba]  <= RCD_W'(T_RCD);
                    end
                end
                CMD_PRE: begin
                    if (addr[10]) begin
                        r_open <= 4'b0000;
                    end else begin
                        r_open[ba] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Mode register, refresh bookkeeping, tRFC and refresh-interval timers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_set  <= 1'b0;
            r_cl        <= 2'd2;
            r_ref_cnt   <= 16'd0;
            r_rfc       <= RFC_W'(0);
            r_ref_timer <= REF_W'(0);
        end else begin
            if (r_rfc != RFC_W'(0)) begin
                r_rfc <= r_rfc - RFC_W'(1);
            end
            // Interval timer saturates at REFRESH_MAX so the late error fires once
            if (r_mode_set && (r_ref_timer < REF_W'(REFRESH_MAX))) begin
                r_ref_timer <= r_ref_timer + REF_W'(1);
            end
            if (w_mrs_ok) begin
                r_mode_set  <= 1'b1;
                r_cl        <= addr[5:4];
                r_ref_timer <= REF_W'(0);
            end
            if (w_cmd == CMD_REF) begin
                if (r_ref_cnt != 16'hFFFF) begin
                    r_ref_cnt <= r_ref_cnt + 16'd1;
                end
                r_rfc       <= RFC_W'(T_RFC);
                r_ref_timer <= REF_W'(0);
            end
        end
    end

    // CAS-latency read pipeline and registered data outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_vld    <= 2'b00;
            r_p_dat[0] <= 32'd0;
            r_p_dat[1] <= 32'd0;
            r_dq_oe    <= 1'b0;
            r_dq_out   <= 32'd0;
        end else begin
            r_p_vld[1] <= w_rd_push && (r_cl == 2'd3);
            if (w_rd_push && (r_cl == 2'd3)) begin
                r_p_dat[1] <= w_rd_word;
            end
            if (w_rd_push && (r_cl != 2'd3)) begin
                r_p_vld[0] <= 1'b1;
                r_p_dat[0] <= w_rd_word;
            end else begin
                r_p_vld[0] <= r_p_vld[1];
                r_p_dat[0] <= r_p_dat[1];
            end
            r_dq_oe <= r_p_vld[0];
            if (r_p_vld[0]) begin
                r_dq_out <= r_p_dat[0];
            end
        end
    end

    // Error pulse, reported code and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_valid <= 1'b0;
            r_err_code  <= 3'd0;
            r_err_flags <= 8'd0;
        end else begin
            r_err_valid <= |w_err;
            r_err_code  <= w_err_code;
            r_err_flags <= r_err_flags | w_err;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_mem[w_mem_idx] <= dq_in;
        end
    end

    assign dq_out        = r_dq_out;
    assign dq_oe         = r_dq_oe;
    assign err_valid     = r_err_valid;
    assign err_code      = r_err_code;
    assign err_flags     = r_err_flags;
    assign mode_set      = r_mode_set;
    assign cas_latency   = r_cl;
    assign refresh_count = r_ref_cnt;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, write/read at CL2 and CL3, error codes,
// refresh-late timing and reset during an in-flight read.
module tb_sdram_responder;

    localparam logic [2:0] C_MRS = 3'b000;
    localparam logic [2:0] C_REF = 3'b001;
    localparam logic [2:0] C_PRE = 3'b010;
    localparam logic [2:0] C_ACT = 3'b011;
    localparam logic [2:0] C_WR  = 3'b100;
    localparam logic [2:0] C_RD  = 3'b101;
    localparam logic [2:0] C_NOP = 3'b111;

    logic        clk;
    logic        rst;
    logic        ras_n;
    logic        cas_n;
    logic        we_n;
    logic [1:0]  ba;
    logic [10:0] addr;
    logic [31:0] dq_in;
    logic [31:0] dq_out;
    logic        dq_oe;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [7:0]  err_flags;
    logic        mode_set;
    logic [1:0]  cas_latency;
    logic [15:0] refresh_count;

    int n_vectors;
    int n_miscompares;
    int late_pulses;
    int late_at;

    sdram_responder dut (
        .clk(clk), .rst(rst), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
        .ba(ba), .addr(addr), .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe),
        .err_valid(err_valid), .err_code(err_code), .err_flags(err_flags),
        .mode_set(mode_set), .cas_latency(cas_latency), .refresh_count(refresh_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one command for one edge, then return to NOP 1ns after the edge
    task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [10:0] a,
                         input logic [31:0] d);
        {ras_n, cas_n, we_n} = c;
        ba = b;
        addr = a;
        dq_in = d;
        @(posedge clk);
        #1;
        {ras_n, cas_n, we_n} = C_NOP;
        ba = 2'd0;
        addr = 11'd0;
        dq_in = 32'd0;
    endtask

    task automatic nop();
        issue(C_NOP, 2'd0, 11'd0, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dq_out"}, dq_out, 32'd0);
        check({tag, "_dq_oe"}, {31'd0, dq_oe}, 32'd0);
        check({tag, "_err_valid"}, {31'd0, err_valid}, 32'd0);
        check({tag, "_err_code"}, {29'd0, err_code}, 32'd0);
        check({tag, "_err_flags"}, {24'd0, err_flags}, 32'd0);
        check({tag, "_mode_set"}, {31'd0, mode_set}, 32'd0);
        check({tag, "_cl"}, {30'd0, cas_latency}, 32'd2);
        check({tag, "_refcnt"}, {16'd0, refresh_count}, 32'd0);
    endtask

    initial begin
        n_vectors = 0;
        n_miscompares = 0;
        rst = 1'b1;
        {ras_n, cas_n, we_n} = C_NOP;
        ba = 2'd0;
        addr = 11'd0;
        dq_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Initialisation sequence
        issue(C_PRE, 2'd0, 11'd0, 32'd0);
        issue(C_PRE, 2'd0, 11'd0, 32'd0);
        issue(C_REF, 2'd0, 11'd0, 32'd0);
        nop();
        nop();
        issue(C_MRS, 2'd0, 11'b01000100000, 32'd0);
        check("init_mode_set", {31'd0, mode_set}, 32'd1);
        check("init_cl", {30'd0, cas_latency}, 32'd2);
        check("init_refcnt", {16'd0, refresh_count}, 32'd1);
        check("init_flags", {24'd0, err_flags}, 32'd0);

        // CL=2 write, precharge, reopen, read back
        issue(C_ACT, 2'd0, 11'd5, 32'd0);
        issue(C_ACT, 2'd0, 11'd5, 32'd0);
        issue(C_WR, 2'd0, 11'h012, 32'hDEADBEEF);
        issue(C_PRE, 2'd0, 11'd0, 32'd0);
        issue(C_ACT, 2'd0, 11'd5, 32'd0);
        issue(C_ACT, 2'd0, 11'd5, 32'd0);
        issue(C_RD, 2'd0, 11'h012, 32'd0);
        check("cl2_oe_early", {31'd0, dq_oe}, 32'd0);
        nop();
        check("cl2_oe", {31'd0, dq_oe}, 32'd1);
        check("cl2_data", dq_out, 32'hDEADBEEF);
        nop();
        check("cl2_oe_after", {31'd0, dq_oe}, 32'd0);
        check("cl2_hold", dq_out, 32'hDEADBEEF);
        // Write immediately followed by read of the same word
        issue(C_WR, 2'd0, 11'h013, 32'h12345678);
        issue(C_RD, 2'd0, 11'h013, 32'd0);
        nop();
        check("wr_rd_oe", {31'd0, dq_oe}, 32'd1);
        check("wr_rd_data", dq_out, 32'h12345678);
        check("cl2_flags", {24'd0, err_flags}, 32'd0);

        // CL=3 with three back-to-back reads
        issue(C_PRE, 2'd0, 11'h400, 32'd0);
        issue(C_MRS, 2'd0, 11'h030, 32'd0);
        check("cl3_cl", {30'd0, cas_latency}, 32'd3);
        issue(C_ACT, 2'd1, 11'd2, 32'd0);
        issue(C_ACT, 2'd1, 11'd2, 32'd0);
        issue(C_WR, 2'd1, 11'd5, 32'hA5A50001);
        issue(C_WR, 2'd1, 11'd6, 32'hA5A50002);
        issue(C_WR, 2'd1, 11'd7, 32'hA5A50003);
        issue(C_RD, 2'd1, 11'd5, 32'd0);
        check("cl3_oe_0", {31'd0, dq_oe}, 32'd0);
        issue(C_RD, 2'd1, 11'd6, 32'd0);
        check("cl3_oe_1", {31'd0, dq_oe}, 32'd0);
        issue(C_RD, 2'd1, 11'd7, 32'd0);
        check("cl3_oe_2", {31'd0, dq_oe}, 32'd1);
        check("cl3_d0", dq_out, 32'hA5A50001);
        nop();
        check("cl3_oe_3", {31'd0, dq_oe}, 32'd1);
        check("cl3_d1", dq_out, 32'hA5A50002);
        nop();
        check("cl3_oe_4", {31'd0, dq_oe}, 32'd1);
        check("cl3_d2", dq_out, 32'hA5A50003);
        nop();
        check("cl3_oe_5", {31'd0, dq_oe}, 32'd0);
        check("cl3_flags", {24'd0, err_flags}, 32'd0);

        // READ on a closed bank, then a row conflict
        issue(C_RD, 2'd2, 11'd0, 32'd0);
        check("norow_valid", {31'd0, err_valid}, 32'd1);
        check("norow_code", {29'd0, err_code}, 32'd3);
        check("norow_flags", {24'd0, err_flags}, 32'h08);
        for (int i = 0; i < 4; i++) begin
            nop();
            check("norow_no_oe", {31'd0, dq_oe}, 32'd0);
        end
        check("norow_pulse_end", {31'd0, err_valid}, 32'd0);
        issue(C_ACT, 2'd0, 11'd5, 32'd0);
        issue(C_ACT, 2'd0, 11'd5, 32'd0);
        check("reissue_ok", {31'd0, err_valid}, 32'd0);
        issue(C_ACT, 2'd0, 11'd6, 32'd0);
        check("conflict_valid", {31'd0, err_valid}, 32'd1);
        check("conflict_code", {29'd0, err_code}, 32'd2);
        check("conflict_flags", {24'd0, err_flags}, 32'h0C);

        // Command inside tRFC, then no refresh for REFRESH_MAX cycles
        issue(C_PRE, 2'd0, 11'h400, 32'd0);
        issue(C_REF, 2'd0, 11'd0, 32'd0);
        check("ref_ok", {31'd0, err_valid}, 32'd0);
        check("ref_cnt2", {16'd0, refresh_count}, 32'd2);
        issue(C_ACT, 2'd0, 11'd1, 32'd0);
        check("trfc_valid", {31'd0, err_valid}, 32'd1);
        check("trfc_code", {29'd0, err_code}, 32'd6);
        check("trfc_flags", {24'd0, err_flags}, 32'h4C);
        late_pulses = 0;
        late_at = -1;
        for (int k = 1; k <= 430; k++) begin
            nop();
            if (err_valid) begin
                late_pulses++;
                if (late_at < 0) late_at = k;
            end
        end
        check("late_pulses", late_pulses, 32'd1);
        check("late_cycle", late_at, 32'd399);
        check("late_flags", {24'd0, err_flags}, 32'hCC);

        // Reset while a read is in flight (CL=3)
        issue(C_RD, 2'd0, 11'd0, 32'd0);
        rst = 1'b1;
        nop();
        check_reset_outputs("midrd");
        nop();
        check("midrd_oe_1", {31'd0, dq_oe}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nop();
            check("midrd_oe_after", {31'd0, dq_oe}, 32'd0);
        end

        // Uninitialised access, then storage retained across reset
        issue(C_ACT, 2'd0, 11'd5, 32'd0);
        check("uninit_valid", {31'd0, err_valid}, 32'd1);
        check("uninit_code", {29'd0, err_code}, 32'd0);
        check("uninit_flags", {24'd0, err_flags}, 32'h01);
        issue(C_MRS, 2'd0, 11'h020, 32'd0);
        check("remrs_ok", {31'd0, err_valid}, 32'd0);
        issue(C_ACT, 2'd0, 11'd5, 32'd0);
        issue(C_ACT, 2'd0, 11'd5, 32'd0);
        issue(C_RD, 2'd0, 11'h012, 32'd0);
        nop();
        check("retain_oe", {31'd0, dq_oe}, 32'd1);
        check("retain_data", dq_out, 32'hDEADBEEF);

        // Bad CAS latency leaves mode untouched
        issue(C_PRE, 2'd0, 11'h400, 32'd0);
        issue(C_MRS, 2'd0, 11'h010, 32'd0);
        check("badmrs_valid", {31'd0, err_valid}, 32'd1);
        check("badmrs_code", {29'd0, err_code}, 32'd1);
        check("badmrs_cl", {30'd0, cas_latency}, 32'd2);
        check("badmrs_flags", {24'd0, err_flags}, 32'h03);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
